// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scan driver with frame-synchronous word swap,
// per-digit blank/dp masks, leading-zero suppression and PWM brightness.
module seg7_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int PWM_BITS       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_en,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [7:0]            disp_seg_o,
  output logic [DIGITS-1:0]     disp_an_o,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [7:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [PWM_BITS-1:0]   r_pwm;
  logic [4*DIGITS-1:0]   r_pend;
  logic                  r_pend_valid;
  logic [4*DIGITS-1:0]   r_active;
  logic [7:0]            r_seg;
  logic [DIGITS-1:0]     r_an;
  logic                  r_frame_done;

  logic                  w_presc_wrap;
  logic                  w_boundary;
  logic [DIGITS-1:0]     w_sel;
  logic [3:0]            w_nib;
  logic                  w_blank;
  logic                  w_dp;
  logic                  w_supp;
  logic                  w_en;
  logic [7:0]            w_raw;
  logic [7:0]            w_seg_next;
  logic [DIGITS-1:0]     w_an_next;

  // Frame boundary detection.
  always_comb begin
    w_presc_wrap = (r_presc == PRESC_LAST);
    w_boundary   = w_presc_wrap && (r_idx == IDX_LAST);
  end

  // Current-digit selection; zero run is tracked from the top digit downwards.
  always_comb begin : digit_sel
    logic v_zero_run;
    w_sel      = '0;
    w_nib      = 4'h0;
    w_blank    = 1'b0;
    w_dp       = 1'b0;
    w_supp     = 1'b0;
    v_zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_zero_run = v_zero_run & (r_active[4*k +: 4] == 4'h0);
      if (r_idx == IW'(k)) begin
        w_sel[k] = 1'b1;
        w_nib    = r_active[4*k +: 4];
        w_blank  = blank_mask[k];
        w_dp     = dp_mask[k];
        w_supp   = lz_en & v_zero_run & (k != 0);
      end else begin
        w_sel[k] = 1'b0;
      end
    end
  end

  // Enable, anode and segment values for the next output register load.
  always_comb begin
    w_en      = (r_pwm <= brightness) & ~w_blank & ~w_supp;
    w_raw     = {w_dp, hex_decode(w_nib)};
    w_an_next = ~(w_sel & {DIGITS{w_en}});
    if (!w_en) begin
      w_seg_next = SEG_OFF;
    end else if (SEG_ACTIVE_LOW) begin
      w_seg_next = ~w_raw;
    end else begin
      w_seg_next = w_raw;
    end
  end

  // Prescaler, digit index and PWM counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_pwm   <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (w_presc_wrap) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Pending/active word; a write landing on the boundary bypasses the pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_active     <= '0;
    end else if (w_boundary) begin
      r_pend_valid <= 1'b0;
      if (we) begin
        r_active <= i_data;
      end else if (r_pend_valid) begin
        r_active <= r_pend;
      end
    end else if (we) begin
      r_pend       <= i_data;
      r_pend_valid <= 1'b1;
    end
  end

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_OFF;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
      r_frame_done <= w_boundary;
    end
  end

  assign disp_seg_o = r_seg;
  assign disp_an_o  = r_an;
  assign frame_done = r_frame_done;

endmodule
